sfifo_burst_drain: RTL and testbench

//  Read-side drain engine for a threshold-signalling synchronous FIFO. Waits
//  for the FIFO's threshold indication (or a flush/timeout), then pops a

---
 rtl/sfifo_drain_pkg.sv | 25 ++
 rtl/sfifo_burst_drain_if.sv | 32 +++
 rtl/sfifo_drain_outreg.sv | 50 +++++
 rtl/sfifo_burst_drain.sv | 131 +++++++++++++
 tb/tb_sfifo_burst_drain.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sfifo_drain_pkg.sv
// Shared types for the FIFO burst drain engine: FSM state encoding and
// the burst-length clamp helper (0 maps to 1, oversize maps to max).
package sfifo_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int unsigned clamp_len(
        input int unsigned len,
        input int unsigned lgmax
    );
        int unsigned maxb;
        maxb = 32'd1 << lgmax;
        if (len == 0)
            return 32'd1;
        else if (len > maxb)
            return maxb;
        else
            return len;
    endfunction

endpackage

// File: rtl/sfifo_burst_drain_if.sv
// Bundle of FIFO read-port, control and output-stream signals.
// master: the drain engine; slave: FIFO/consumer side.
interface sfifo_burst_drain_if #(
    parameter int BW         = 8,
    parameter int LGFLEN     = 4,
    parameter int LGMAXBURST = 3
);
    logic                  i_int;
    logic                  i_empty;
    logic [LGFLEN:0]       i_fill;
    logic [BW-1:0]         i_fdata;
    logic                  o_rd;
    logic [LGMAXBURST:0]   i_burst_len;
    logic                  i_flush;
    logic                  o_valid;
    logic                  i_ready;
    logic [BW-1:0]         o_data;
    logic                  o_last;
    logic                  o_busy;

    modport master (
        input  i_int, i_empty, i_fill, i_fdata,
        input  i_burst_len, i_flush, i_ready,
        output o_rd, o_valid, o_data, o_last, o_busy
    );

    modport slave (
        output i_int, i_empty, i_fill, i_fdata,
        output i_burst_len, i_flush, i_ready,
        input  o_rd, o_valid, o_data, o_last, o_busy
    );
endinterface

// File: rtl/sfifo_drain_outreg.sv
// Registered valid/ready output slot holding one beat (data + last).
// Ports: i_ld loads a beat; i_ready retires it; o_valid/o_data/o_last out.
module sfifo_drain_outreg #(
    parameter int BW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ld,
    input  logic [BW-1:0] i_ld_data,
    input  logic          i_ld_last,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [BW-1:0] o_data,
    output logic          o_last
);
    logic          valid_q, valid_d;
    logic [BW-1:0] data_q, data_d;
    logic          last_q, last_d;

    // A load is only issued when the slot is free or retiring this cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (i_ld) begin
            valid_d = 1'b1;
            data_d  = i_ld_data;
            last_d  = i_ld_last;
        end else if (i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
endmodule

// File: rtl/sfifo_burst_drain.sv
// Burst drain engine: waits for FIFO threshold/flush(/timeout), pops a
// bounded burst onto a valid/ready stream with o_last on the final beat.
// Ports: i_clk, i_reset_n (async active-low), bus (master modport).
// Optional: SFIFO_DRAIN_TIMEOUT_EN enables the idle-timeout trigger.
module sfifo_burst_drain
    import sfifo_drain_pkg::*;
#(
    parameter int BW         = 8,
    parameter int LGFLEN     = 4,
    parameter int LGMAXBURST = 3,
    parameter int LGTIMEOUT  = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    sfifo_burst_drain_if.master  bus
);
    localparam int RW = LGMAXBURST + 1;
    localparam int FW = LGFLEN + 1;

    state_e        state_q, state_d;
    logic [RW-1:0] remain_q, remain_d;
    logic          flush_pend_q, flush_pend_d;
    logic [FW-1:0] fill;
    logic [RW-1:0] eff_len, first_len;
    logic          trig, start, rd, ld_last, out_valid, tmo_hit;

    assign fill = bus.i_fill;

`ifdef SFIFO_DRAIN_TIMEOUT_EN
    logic [LGTIMEOUT-1:0] tmo_q, tmo_d;

    assign tmo_hit = (state_q == ST_IDLE) && (&tmo_q);

    // Counts idle cycles with data waiting below threshold; restarts on hit.
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_IDLE && !bus.i_empty && !bus.i_int && !tmo_hit)
            tmo_d = tmo_q + LGTIMEOUT'(1);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end
`else
    logic tmo_unused;
    assign tmo_unused = |LGTIMEOUT;
    assign tmo_hit    = 1'b0;
`endif

    // Burst size is the clamped request, never more than what is stored.
    always_comb begin
        eff_len = RW'(clamp_len(32'(bus.i_burst_len), LGMAXBURST));
        if (32'(fill) < 32'(eff_len))
            first_len = RW'(fill);
        else
            first_len = eff_len;
    end

    assign trig  = bus.i_int || flush_pend_q || bus.i_flush || tmo_hit;
    assign start = (state_q == ST_IDLE) && trig && (fill != '0);

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Next-state and counters
    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        flush_pend_d = flush_pend_q;
        if (start)
            flush_pend_d = 1'b0;
        else if (bus.i_flush)
            flush_pend_d = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_BURST;
                    remain_d = first_len;
                end
            end
            ST_BURST: begin
                if (rd) begin
                    remain_d = remain_q - RW'(1);
                    if (ld_last)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_valid && bus.i_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ld_last = (remain_q == RW'(1));
        rd      = (state_q == ST_BURST) && !bus.i_empty &&
                  (remain_q != '0) && (!out_valid || bus.i_ready);
    end

    sfifo_drain_outreg #(.BW(BW)) u_outreg (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_ld      (rd),
        .i_ld_data (bus.i_fdata),
        .i_ld_last (ld_last),
        .i_ready   (bus.i_ready),
        .o_valid   (out_valid),
        .o_data    (bus.o_data),
        .o_last    (bus.o_last)
    );

    assign bus.o_rd    = rd;
    assign bus.o_valid = out_valid;
    assign bus.o_busy  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_sfifo_burst_drain.sv
// Directed self-checking bench for sfifo_burst_drain with a FIFO model
// and a stream capture queue.
module tb_sfifo_burst_drain;
`ifdef SFIFO_DRAIN_TIMEOUT_EN
    localparam int TO = 3;
`else
    localparam int TO = 6;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sfifo_burst_drain_if #(.BW(8), .LGFLEN(4), .LGMAXBURST(3)) bus ();

    sfifo_burst_drain #(
        .BW(8), .LGFLEN(4), .LGMAXBURST(3), .LGTIMEOUT(TO)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus.master)
    );

    // FIFO model
    logic       clr = 1'b1;
    logic [7:0] load_base = 8'h00;
    int         load_n = 0;
    logic [4:0] wp, rp;
    logic [7:0] mem [0:31];

    always @(posedge clk) begin
        if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (load_n != 0) begin
                for (int i = 0; i < load_n; i++)
                    mem[wp + 5'(i)] <= load_base + 8'(i);
                wp <= wp + 5'(load_n);
            end
            if (bus.o_rd)
                rp <= rp + 5'd1;
        end
    end

    assign bus.i_fill  = wp - rp;
    assign bus.i_empty = (wp == rp);
    assign bus.i_fdata = mem[rp];

    // Monitors
    int         cyc = 0;
    int         pops = 0;
    int         bad_under = 0;
    int         bad_slot = 0;
    int         pop_cyc [$];
    logic [8:0] rx [$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (bus.o_valid && bus.i_ready)
                rx.push_back({bus.o_last, bus.o_data});
            if (bus.o_rd) begin
                pops = pops + 1;
                pop_cyc.push_back(cyc);
                if (bus.i_empty) bad_under = bad_under + 1;
                if (bus.o_valid && !bus.i_ready) bad_slot = bad_slot + 1;
            end
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic load(input logic [7:0] base, input int n);
        load_base = base;
        load_n = n;
        @(negedge clk);
        load_n = 0;
    endtask

    task automatic fifo_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rx.delete();
    endtask

    // Bounded wait for n captured beats, then for the engine to go quiet.
    task automatic wait_beats(input int n, input int bound, input string nm);
        int k;
        k = 0;
        while (rx.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (rx.size() != n)
            $display("FAIL %s beat_count: got %0d want %0d", nm, rx.size(), n);
        else
            n_pass++;
        k = 0;
        while ((bus.o_busy || bus.o_valid) && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic int_until_busy();
        int k;
        bus.i_int = 1'b1;
        k = 0;
        while (!bus.o_busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        bus.i_int = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_int = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_burst_len = 4'd4;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.o_valid, bus.o_last, bus.o_rd, bus.o_busy} !== 4'b0000)
            $display("FAIL reset_ctl: got %b want 0000",
                     {bus.o_valid, bus.o_last, bus.o_rd, bus.o_busy});
        else n_pass++;
        n_checks++;
        if (bus.o_data !== 8'h00)
            $display("FAIL reset_data: got %h want 00", bus.o_data);
        else n_pass++;
        rst_n = 1'b1;
        fifo_clear();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.o_busy !== 1'b0)
            $display("FAIL reset_idle: got %b want 0", bus.o_busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [8:0] exp [$];
        int p0, q0, span;
        exp = '{9'h010, 9'h011, 9'h012, 9'h113};
        fifo_clear();
        bus.i_burst_len = 4'd4;
        bus.i_ready = 1'b1;
        load(8'h10, 5);
        p0 = pops;
        q0 = pop_cyc.size();
        int_until_busy();
        wait_beats(4, 40, "basic");
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx[i] !== exp[i])
                $display("FAIL basic_beat%0d: got %h want %h", i, rx[i], exp[i]);
            else n_pass++;
        end
        n_checks++;
        if (pops - p0 != 4)
            $display("FAIL basic_pops: got %0d want 4", pops - p0);
        else n_pass++;
        span = (pop_cyc.size() >= q0 + 4) ? pop_cyc[q0 + 3] - pop_cyc[q0] : -1;
        n_checks++;
        if (span != 3)
            $display("FAIL basic_pop_span: got %0d want 3", span);
        else n_pass++;
        n_checks++;
        if (bus.i_fill !== 5'd1)
            $display("FAIL basic_fill: got %0d want 1", bus.i_fill);
        else n_pass++;
        n_checks++;
        if (bus.o_busy !== 1'b0)
            $display("FAIL basic_busy: got %b want 0", bus.o_busy);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [8:0] exp [$];
        logic       pv, pr;
        logic [7:0] pd;
        int         holds, k, s0;
        exp = '{9'h020, 9'h021, 9'h022, 9'h123};
        fifo_clear();
        bus.i_burst_len = 4'd4;
        bus.i_ready = 1'b0;
        load(8'h20, 4);
        s0 = bad_slot;
        bus.i_int = 1'b1;
        pv = 1'b0;
        pr = 1'b0;
        pd = 8'h00;
        holds = 0;
        k = 0;
        while (rx.size() < 4 && k < 60) begin
            @(negedge clk);
            k++;
            if (bus.o_busy) bus.i_int = 1'b0;
            if (pv && !pr) begin
                holds++;
                n_checks++;
                if ({bus.o_valid, bus.o_data} !== {1'b1, pd})
                    $display("FAIL bp_hold: got %b/%h want 1/%h",
                             bus.o_valid, bus.o_data, pd);
                else n_pass++;
            end
            pv = bus.o_valid;
            pd = bus.o_data;
            bus.i_ready = ~bus.i_ready;
            pr = bus.i_ready;
        end
        bus.i_int = 1'b0;
        bus.i_ready = 1'b1;
        wait_beats(4, 20, "bp");
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx[i] !== exp[i])
                $display("FAIL bp_beat%0d: got %h want %h", i, rx[i], exp[i]);
            else n_pass++;
        end
        n_checks++;
        if (holds < 2)
            $display("FAIL bp_stalls_seen: got %0d want >=2", holds);
        else n_pass++;
        n_checks++;
        if (bad_slot - s0 != 0)
            $display("FAIL bp_rd_when_full: got %0d want 0", bad_slot - s0);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic [8:0] exp [$];
        exp = '{9'h030, 9'h131};
        fifo_clear();
        bus.i_burst_len = 4'd4;
        bus.i_ready = 1'b1;
        load(8'h30, 2);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        wait_beats(2, 30, "flush");
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rx[i] !== exp[i])
                $display("FAIL flush_beat%0d: got %h want %h", i, rx[i], exp[i]);
            else n_pass++;
        end
        n_checks++;
        if (bus.i_fill !== 5'd0)
            $display("FAIL flush_fill: got %0d want 0", bus.i_fill);
        else n_pass++;
    endtask

    task automatic test_flush_pend();
        logic [8:0] exp [$];
        exp = '{9'h040, 9'h141, 9'h142};
        fifo_clear();
        bus.i_burst_len = 4'd2;
        bus.i_ready = 1'b1;
        load(8'h40, 3);
        int_until_busy();
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        wait_beats(3, 40, "fpend");
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rx[i] !== exp[i])
                $display("FAIL fpend_beat%0d: got %h want %h", i, rx[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_len_bounds();
        logic [8:0] exp [$];
        fifo_clear();
        bus.i_burst_len = 4'd0;
        bus.i_ready = 1'b1;
        load(8'h50, 2);
        bus.i_int = 1'b1;
        wait_beats(2, 30, "len0");
        bus.i_int = 1'b0;
        exp = '{9'h150, 9'h151};
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rx[i] !== exp[i])
                $display("FAIL len0_beat%0d: got %h want %h", i, rx[i], exp[i]);
            else n_pass++;
        end
        fifo_clear();
        bus.i_burst_len = 4'd15;
        load(8'h60, 10);
        bus.i_int = 1'b1;
        wait_beats(10, 60, "len15");
        bus.i_int = 1'b0;
        exp = '{9'h060, 9'h061, 9'h062, 9'h063, 9'h064,
                9'h065, 9'h066, 9'h167, 9'h068, 9'h169};
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (rx[i] !== exp[i])
                $display("FAIL len15_beat%0d: got %h want %h", i, rx[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        int k;
        fifo_clear();
        bus.i_burst_len = 4'd4;
        bus.i_ready = 1'b1;
        load(8'h70, 4);
        bus.i_int = 1'b1;
        k = 0;
        while (rx.size() < 1 && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.o_busy) bus.i_int = 1'b0;
        end
        bus.i_int = 1'b0;
        n_checks++;
        if ({bus.o_valid, bus.o_data} !== 9'h171)
            $display("FAIL arst_pre: got %b/%h want 1/71", bus.o_valid, bus.o_data);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_valid, bus.o_rd, bus.o_busy} !== 3'b000)
            $display("FAIL arst_now: got %b want 000",
                     {bus.o_valid, bus.o_rd, bus.o_busy});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
`ifndef SFIFO_DRAIN_TIMEOUT_EN
        repeat (30) @(negedge clk);
        n_checks++;
        if (rx.size() != 1 || bus.o_busy !== 1'b0)
            $display("FAIL arst_quiet: got beats=%0d busy=%b want 1/0",
                     rx.size(), bus.o_busy);
        else n_pass++;
`endif
        fifo_clear();
    endtask

    task automatic test_timeout();
        fifo_clear();
        bus.i_burst_len = 4'd4;
        bus.i_ready = 1'b1;
        bus.i_int = 1'b0;
        load(8'h80, 1);
`ifdef SFIFO_DRAIN_TIMEOUT_EN
        wait_beats(1, 30, "tmo");
        n_checks++;
        if (rx[0] !== 9'h180)
            $display("FAIL tmo_beat: got %h want 180", rx[0]);
        else n_pass++;
`else
        repeat (100) @(negedge clk);
        n_checks++;
        if (rx.size() != 0 || bus.o_busy !== 1'b0)
            $display("FAIL no_tmo: got beats=%0d busy=%b want 0/0",
                     rx.size(), bus.o_busy);
        else n_pass++;
`endif
    endtask

    initial begin
        bus.i_int = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_ready = 1'b1;
        bus.i_burst_len = 4'd4;
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_flush_pend();
        test_len_bounds();
        test_async_reset();
        test_timeout();
        n_checks++;
        if (bad_under != 0)
            $display("FAIL underflow_pops: got %0d want 0", bad_under);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
